cdb_result_arbiter: RTL
=======================

Name: cdb_result_arbiter

Overview:
- Write-back end of the reservation-station protocol. RS helpers pick an entry whose Qj/Qk are zero and issue it; this block collects the finished results from the functional units and broadcasts one (ROB tag, value) pair per cycle on the common data bus (CDB).
- RS and ROB use the CDB broadcast to clear matching Qj/Qk/Ql/Qm fields and to mark ROB entries done.
- Each source has a small skid FIFO; sources are served round-robin.

Parameters:
- N_SRC, 3, number of result sources (0=ALU, 1=LOAD, 2=STORE/misc).
- TAG_W, 4, ROB tag width; tag 0 means "no dependency" and is never broadcast.
- DATA_W, 32, result value width.
- DEPTH, 2, per-source FIFO depth (power of 2, ≥2).

Ports:
- clk_in  input  1  clock, all state updates on the rising edge.
- rst_n_in  input  1  synchronous, active-low reset.
- rdy_in  input  1  global pause; when 0 the block holds all state.
- flush_in  input  1  misprediction flush; discards all buffered results.
- src_valid  input  N_SRC  per-source result valid.
- src_tag  input  N_SRC*TAG_W  per-source ROB tag; source i occupies bits [i*TAG_W +: TAG_W].
- src_value  input  N_SRC*DATA_W  per-source result value, same packing as src_tag.
- src_ready  output  N_SRC  per-source accept; a push occurs when src_valid[i] && src_ready[i].
- cdb_valid  output  1  broadcast valid (registered).
- cdb_tag  output  TAG_W  broadcast ROB tag (registered).
- cdb_value  output  DATA_W  broadcast value (registered).

Behaviour:
- Reset (rst_n_in=0 at a clock edge):
  - all FIFO counts and pointers = 0;
  - cdb_valid=0, cdb_tag=0, cdb_value=0;
  - rr_last = N_SRC-1, so source 0 has first priority;
  - reset overrides flush_in and rdy_in.
- src_ready[i] = rdy_in && !flush_in && (count[i] < DEPTH).
  - Depends only on registered state and the global inputs, never on src_valid.
  - When a FIFO is full, ready stays 0 even in a cycle where that FIFO is popped. No same-cycle refill.
- Push with tag 0: the handshake completes but nothing is stored (entry dropped).
- Arbitration (combinational, from registered counts):
  - The winner is the first non-empty FIFO scanning from rr_last+1 upward, wrapping modulo N_SRC.
  - No winner if all FIFOs are empty.
- Each cycle with rdy_in=1 and flush_in=0:
  - With a winner w: pop the head of w; cdb_valid<=1; cdb_tag<=head tag; cdb_value<=head value; rr_last<=w.
  - With no winner: cdb_valid<=0. cdb_tag/cdb_value hold their previous values (don't-care). rr_last holds.
  - Pushes are written into the FIFO tails in the same cycle.
- Latency: a result pushed at edge t into an empty FIFO can win at t+1 and appear on the CDB in the cycle after edge t+1, i.e. it is visible one cycle after acceptance. No bypass from src_* to cdb_*.
- Simultaneous push and pop on one FIFO (count between 1 and DEPTH-1): count is unchanged, both pointers advance.
- Pointer wrap: read/write pointers wrap modulo DEPTH. count is DEPTH-width+1 bits and ranges 0..DEPTH.
- flush_in=1 (with rdy_in=1):
  - next state: all counts and pointers = 0, cdb_valid=0;
  - pushes in that cycle are discarded (src_ready is already 0);
  - rr_last is unchanged.
- rdy_in=0:
  - FIFOs, pointers and rr_last are frozen; cdb_valid<=0 so consumers never see a duplicate broadcast;
  - flush_in is ignored while rdy_in=0.
- Ordering guarantees:
  - Per source, results are broadcast in FIFO order.
  - Across sources there is no ordering; the ROB tag identifies each result.
- Fairness: with all sources continuously non-empty, grants rotate 0,1,2,0,...; no source waits more than N_SRC-1 grants.

Test Plan:
- Reset and single push:
  - Stimulus: deassert reset, then push ALU tag=5 value=0x12345678 at edge t.
  - Required: cdb_valid=1, tag=5, value=0x12345678 after edge t+1; cdb_valid=0 after edge t+2; src_ready=3'b111 throughout.
- Round-robin fairness:
  - Stimulus: push tags 1, 2, 3 on sources 0, 1, 2 in the same cycle, then tags 4, 5, 6 the next cycle.
  - Required: CDB tag order is 1, 2, 3, 4, 5, 6 on consecutive cycles.
- Full and backpressure:
  - Stimulus: hold source 1 valid for 4 cycles with tags 7..10 while sources 0 and 2 are also busy.
  - Required: src_ready[1] drops to 0 when count=2; tags are broadcast in order 7, 8, 9, 10, none lost or duplicated.
- Flush:
  - Stimulus: fill source 0 with tags 3 and 4, then assert flush_in for one cycle.
  - Required: cdb_valid=0 on the next cycle; tag 4 is never broadcast; a push of tag 9 after flush appears on the CDB one cycle later.
- Pause:
  - Stimulus: with tag 6 buffered, drive rdy_in=0 for 3 cycles.
  - Required: cdb_valid=0 and src_ready=0 during the pause; tag 6 is broadcast exactly once in the cycle after rdy_in returns to 1.
- Tag-0 drop and wrap:
  - Stimulus: push tag 0 on source 2, then 5 pushes on source 2 (tags 1..5).
  - Required: no broadcast for tag 0; tags 1..5 are broadcast in order, exercising pointer wrap-around.

Source files
------------

// File: rtl/cdb_result_arbiter.sv
// Write-back arbiter: per-source skid FIFOs drained round-robin onto a
// registered common data bus, one (ROB tag, value) broadcast per cycle.

module cdb_src_fifo #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              clr_in,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [DATA_W-1:0] value_in,
    output logic              nonempty,
    output logic              full,
    output logic [TAG_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_value
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][TAG_W-1:0]  tag_mem_q, tag_mem_d;
    logic [DEPTH-1:0][DATA_W-1:0] val_mem_q, val_mem_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        tag_mem_d = tag_mem_q;
        val_mem_d = val_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clr_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_in) begin
                tag_mem_d[wr_ptr_q] = tag_in;
                val_mem_d[wr_ptr_q] = value_in;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop_in) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_in) - CNT_W'(pop_in);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        tag_mem_q <= tag_mem_d;
        val_mem_q <= val_mem_d;
    end

    assign nonempty   = (count_q != '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign head_tag   = tag_mem_q[rd_ptr_q];
    assign head_value = val_mem_q[rd_ptr_q];
endmodule

module cdb_result_arbiter #(
    parameter int N_SRC  = 3,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    input  logic [N_SRC*DATA_W-1:0] src_value,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_value
);
    localparam int RR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0][TAG_W-1:0]  src_tag_a, head_tag;
    logic [N_SRC-1:0][DATA_W-1:0] src_value_a, head_value;
    logic [N_SRC-1:0]             nonempty, full, push, pop;
    logic                         adv, clr, win_vld;
    logic [RR_W-1:0]              win, rr_last_q, rr_last_d;
    logic                         cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]             cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]            cdb_value_q, cdb_value_d;

    assign src_tag_a   = src_tag;
    assign src_value_a = src_value;
    assign adv         = rdy_in && !flush_in;
    assign clr         = rdy_in && flush_in;
    // Ready comes from registered fullness only: a full FIFO never refills in its pop cycle.
    assign src_ready   = {N_SRC{adv}} & ~full;

    always_comb begin
        win_vld = 1'b0;
        win     = rr_last_q;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!win_vld && nonempty[(int'(rr_last_q) + k) % N_SRC]) begin
                win_vld = 1'b1;
                win     = RR_W'((int'(rr_last_q) + k) % N_SRC);
            end
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        // Tag 0 completes the handshake but is never stored.
        assign push[g] = src_valid[g] && src_ready[g] && (src_tag_a[g] != '0);
        assign pop[g]  = adv && win_vld && (win == RR_W'(g));

        cdb_src_fifo #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .clr_in    (clr),
            .push_in   (push[g]),
            .pop_in    (pop[g]),
            .tag_in    (src_tag_a[g]),
            .value_in  (src_value_a[g]),
            .nonempty  (nonempty[g]),
            .full      (full[g]),
            .head_tag  (head_tag[g]),
            .head_value(head_value[g])
        );
    end

    always_comb begin
        rr_last_d   = rr_last_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        if (adv && win_vld) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = head_tag[win];
            cdb_value_d = head_value[win];
            rr_last_d   = win;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rr_last_q   <= RR_W'(N_SRC - 1);
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
endmodule
